// File: rtl/conv_encoder_punct.sv
// Convolutional encoder with run-time constraint length, rate 1/2 or 1/3,
// optional zero-tail termination and periodic puncturing. One information
// bit per cycle in, one coded symbol (data + keep mask) per cycle out.
module conv_encoder_punct #(
  parameter int unsigned MAX_K         = 9,
  parameter int unsigned MAX_CODE_RATE = 3,
  parameter int unsigned PUNCT_PERIOD  = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  // frame configuration, sampled on i_start in IDLE only
  input  logic                                         i_start,
  input  logic [3:0]                                   i_k,
  input  logic                                         i_code_rate,
  input  logic [MAX_CODE_RATE-1:0][MAX_K-1:0]          i_gen_poly,
  input  logic                                         i_term,
  input  logic                                         i_punct_en,
  input  logic [$clog2(PUNCT_PERIOD):0]                i_punct_len,
  input  logic [PUNCT_PERIOD-1:0][MAX_CODE_RATE-1:0]   i_punct_mat,
  // information bit stream
  input  logic                                         i_in_valid,
  input  logic                                         i_in_bit,
  input  logic                                         i_in_last,
  output logic                                         o_in_ready,
  // coded symbol stream
  output logic                                         o_out_valid,
  output logic [MAX_CODE_RATE-1:0]                     o_out_data,
  output logic [MAX_CODE_RATE-1:0]                     o_out_mask,
  input  logic                                         i_out_ready,
  // status
  output logic                                         o_busy,
  output logic                                         o_frame_done
);

  localparam int unsigned LenW = $clog2(PUNCT_PERIOD) + 1;
  localparam logic [3:0]  MaxK4 = 4'(MAX_K);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StTail,
    StDrain
  } state_e;

  state_e state_q, state_d;

  // Latched frame configuration
  logic [3:0]                               k_q;
  logic                                     term_q;
  logic                                     punct_en_q;
  logic [LenW-1:0]                          len_q;
  logic [MAX_CODE_RATE-1:0]                 rate_mask_q;
  logic [MAX_CODE_RATE-1:0][MAX_K-1:0]      poly_q;
  logic [PUNCT_PERIOD-1:0][MAX_CODE_RATE-1:0] mat_q;

  // Encoder state
  logic [MAX_K-2:0]  sr_q;
  logic [LenW-1:0]   col_q;
  logic [3:0]        tail_cnt_q, tail_cnt_d;

  // Output register
  logic                      out_valid_q;
  logic [MAX_CODE_RATE-1:0]  out_data_q;
  logic [MAX_CODE_RATE-1:0]  out_mask_q;

  // Configuration as it will be latched on start
  logic [3:0]                           k_in;
  logic [MAX_K-1:0]                     tap_mask;
  logic [MAX_CODE_RATE-1:0]             rate_mask_in;
  logic [MAX_CODE_RATE-1:0][MAX_K-1:0]  poly_in;
  logic [LenW-1:0]                      len_in;

  // Datapath / handshake
  logic                      start_fire;
  logic                      slot_free;
  logic                      accept;
  logic                      tail_step;
  logic                      step;
  logic                      step_bit;
  logic [MAX_K-1:0]          window;
  logic [MAX_CODE_RATE-1:0]  enc;
  logic [MAX_CODE_RATE-1:0]  col_mask;
  logic [MAX_CODE_RATE-1:0]  step_mask;
  logic [LenW-1:0]           col_inc;
  logic                      frame_done;

  // Clamp illegal K to MAX_K and pre-mask polynomials so unused taps and the
  // third generator (in rate 1/2) contribute nothing downstream.
  always_comb begin
    k_in = i_k;
    if ((i_k < 4'd3) || (i_k > MaxK4)) begin
      k_in = MaxK4;
    end
    tap_mask = '0;
    for (int i = 0; i < MAX_K; i++) begin
      tap_mask[i] = (4'(i) < k_in);
    end
    rate_mask_in = '0;
    for (int j = 0; j < MAX_CODE_RATE; j++) begin
      rate_mask_in[j] = (j < 2) || (i_code_rate && (j < 3));
    end
    poly_in = '0;
    for (int j = 0; j < MAX_CODE_RATE; j++) begin
      poly_in[j] = rate_mask_in[j] ? (i_gen_poly[j] & tap_mask) : '0;
    end
    len_in = i_punct_len;
    if ((i_punct_len == '0) || (i_punct_len > LenW'(PUNCT_PERIOD))) begin
      len_in = LenW'(PUNCT_PERIOD);
    end
  end

  // Step qualification, encoding and puncture mask selection
  always_comb begin
    start_fire = (state_q == StIdle) && i_start;
    slot_free  = !out_valid_q || i_out_ready;
    accept     = (state_q == StRun) && slot_free && i_in_valid;
    tail_step  = (state_q == StTail) && slot_free;
    step       = accept || tail_step;
    // tail steps shift in zeros
    step_bit   = accept && i_in_bit;
    window     = {sr_q, step_bit};
    enc        = '0;
    for (int j = 0; j < MAX_CODE_RATE; j++) begin
      enc[j] = ^(window & poly_q[j]);
    end
    col_mask = '0;
    for (int p = 0; p < PUNCT_PERIOD; p++) begin
      if (col_q == LenW'(p)) begin
        col_mask = mat_q[p];
      end
    end
    step_mask = punct_en_q ? (col_mask & rate_mask_q) : rate_mask_q;
    col_inc   = col_q + LenW'(1);
  end

  // Next-state logic for the frame FSM and tail counter
  always_comb begin
    state_d    = state_q;
    tail_cnt_d = tail_cnt_q;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        tail_cnt_d = '0;
        if (accept && i_in_last) begin
          state_d = term_q ? StTail : StDrain;
        end
      end
      StTail: begin
        if (tail_step) begin
          if (tail_cnt_q == (k_q - 4'd2)) begin
            state_d = StDrain;
          end else begin
            tail_cnt_d = tail_cnt_q + 4'd1;
          end
        end
      end
      StDrain: begin
        // final symbol handshakes now, or nothing is pending
        if (slot_free) begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and tail counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tail_cnt_q <= tail_cnt_d;
    end
  end

  // Configuration latch, taken only when a frame starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q         <= '0;
      term_q      <= 1'b0;
      punct_en_q  <= 1'b0;
      len_q       <= '0;
      rate_mask_q <= '0;
      poly_q      <= '0;
      mat_q       <= '0;
    end else if (start_fire) begin
      k_q         <= k_in;
      term_q      <= i_term;
      punct_en_q  <= i_punct_en;
      len_q       <= len_in;
      rate_mask_q <= rate_mask_in;
      poly_q      <= poly_in;
      mat_q       <= i_punct_mat;
    end
  end

  // Shift register and puncture column advance on every encode step,
  // including steps whose symbol is fully punctured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      col_q <= '0;
    end else if (start_fire) begin
      sr_q  <= '0;
      col_q <= '0;
    end else if (step) begin
      sr_q  <= window[MAX_K-2:0];
      col_q <= (col_inc >= len_q) ? '0 : col_inc;
    end
  end

  // Single-entry output register; an all-zero mask produces no beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
    end else if (slot_free) begin
      out_valid_q <= step && (step_mask != '0);
      if (step) begin
        out_data_q <= enc;
        out_mask_q <= step_mask;
      end
    end
  end

  // Output assignments
  always_comb begin
    o_in_ready   = (state_q == StRun) && slot_free;
    o_out_valid  = out_valid_q;
    o_out_data   = out_data_q;
    o_out_mask   = out_mask_q;
    o_busy       = (state_q != StIdle);
    o_frame_done = frame_done;
  end

endmodule
